serial_adder: RTL and testbench
===============================

# serial_adder

Parametrised multi-cycle binary adder/subtractor. It processes two WIDTH-bit operands DIGIT bits per clock through a registered carry, and returns sum, carry-out and signed overflow under a start/ready/done handshake. It generalises the team's single-bit gate-level full-adder cell to arbitrary width, with a subtract mode and an area/latency trade-off set by DIGIT. It sits between operand registers and any consumer that can tolerate WIDTH/DIGIT cycles of latency.

## Interface
- WIDTH, 8: operand and result width in bits; must be 2 or more.
- DIGIT, 1: bits added per cycle; must divide WIDTH, otherwise elaboration fails. N = WIDTH/DIGIT is the number of digit steps.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only while ready=1.
- a_in  input  WIDTH  operand A; sampled on the accept edge.
- b_in  input  WIDTH  operand B; sampled on the accept edge.
- cin  input  1  carry-in for add, borrow-in for subtract; sampled on the accept edge.
- sub  input  1  0 = A+B+cin, 1 = A−B−cin; sampled on the accept edge.
- ready  output  1  high in IDLE and DONE.
- done  output  1  one-cycle pulse marking a valid result.
- sum_out  output  WIDTH  result; held from done until the next accept.
- cout  output  1  final carry-out. In subtract mode it is the inverted borrow: 1 means no borrow.
- ovf  output  1  two's-complement overflow of the operation.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE, ready=1, done=0, sum_out=0, cout=0, ovf=0, step counter=0.
- A start is accepted on an edge where start=1 and ready=1. On that edge:
  - A is latched into a shift register.
  - B is latched into a shift register, bitwise inverted when sub=1.
  - The carry flop loads cin XOR sub.
  - The MSBs of A and effective B are latched for the overflow check.
  - The counter clears and the state becomes RUN.
- Each RUN edge:
  - {c, s} = A[DIGIT-1:0] + Beff[DIGIT-1:0] + carry, using the adder_digit slice.
  - carry <= c.
  - The A and B registers shift right by DIGIT.
  - s shifts into the top DIGIT bits of the result register, which shifts right by DIGIT.
  - The counter increments.
- On the RUN edge that processes step N−1, the state becomes DONE. On that same edge:
  - sum_out takes the completed result.
  - cout <= c.
  - ovf <= (a_msb == beff_msb) && (result_msb != a_msb).
- DONE lasts exactly one cycle with done=1. It then goes to IDLE, or back to RUN if start is asserted in DONE (back-to-back operation).
- start while in RUN is ignored. Operand inputs are don't-care outside accept edges.
- All arithmetic wraps modulo 2^WIDTH; no saturation.
- Reset mid-operation returns to the reset state: no done, and sum_out/cout/ovf are cleared.
- rst and start asserted together: rst wins and the start is dropped.

## Timing
- Accept at edge 0. Digit steps occur at edges 1..N. done is high in the cycle after edge N, giving a latency of N cycles.
- ready falls after edge 0 and rises again after edge N.
- Throughput is one operation per N+1 cycles when start is held high: accept in DONE at edge N+1.
- sum_out, cout and ovf change only on the completion edge or on reset; they are stable while done=1 and afterwards.
- Outputs are registered. No combinational path exists from inputs to outputs except ready, which derives only from state.

## Structure
- serial_adder_pkg holds the state enum (IDLE, RUN, DONE) and a helper that computes N with its divisibility check.
- Sub-module adder_digit is a combinational DIGIT-bit adder slice (a, b, ci → s, co), parametrised by DIGIT. It is the only arithmetic in the block.
- The top level contains the FSM, step counter, operand and result shift registers, and the carry flop.

## Test plan
- WIDTH=8, DIGIT=1. Reset, then accept a=0x00, b=0x00, cin=0, sub=0 → done exactly 8 cycles after accept, sum_out=0x00, cout=0, ovf=0. During reset: ready=1 and all outputs 0.
- a=0xFF, b=0x01, add → sum_out=0x00, cout=1, ovf=0. Then a=0x7F, b=0x01 → sum_out=0x80, cout=0, ovf=1.
- Subtract: a=0x05, b=0x07, sub=1, cin=0 → sum_out=0xFE, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01, sub=1 → 0x7F, cout=1, ovf=1.
- Assert start throughout RUN (ignored), then keep it high in DONE with new operands (0x10 + 0x20) → second done 9 cycles after the first, sum_out=0x30.
- Assert rst at the 4th RUN cycle → no done pulse; the next cycle shows ready=1 and sum_out=0. A fresh accept then computes correctly. rst and start together → the operation does not begin.
- WIDTH=8, DIGIT=4: a=0x3C, b=0x0A, cin=1 → done 2 cycles after accept, sum_out=0x47, cout=0, ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder shared types and helpers.
// FSM states and digit-step count derivation.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns 0 when digit does not evenly divide width.
   function automatic int calc_steps(input int width, input int digit);
      if (digit < 1 || (width % digit) != 0)
         return 0;
      return width / digit;
   endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// adder_digit: combinational DIGIT-bit full-adder slice.
// The only arithmetic in serial_adder.
module adder_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co
);

   logic [DIGIT:0] t;

   assign t       = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
   assign {co, s} = t;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract, DIGIT bits per clock.
// Start/ready/done handshake, registered carry, sum, cout, ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin,
   input  logic             sub,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = calc_steps(WIDTH, DIGIT);
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (N == 0 || WIDTH < 2) begin : g_bad_params
      $error("serial_adder: DIGIT must divide WIDTH and WIDTH >= 2");
   end

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic [WIDTH-1:0] res_next, s_ext, b_eff;
   logic [CW-1:0]    cnt;
   logic             carry, a_msb, b_msb;
   logic [DIGIT-1:0] s;
   logic             c;
   logic             accept, last;

   adder_digit #(.DIGIT(DIGIT)) u_digit (
      .a  (a_sr[DIGIT-1:0]),
      .b  (b_sr[DIGIT-1:0]),
      .ci (carry),
      .s  (s),
      .co (c)
   );

   assign ready    = (state != RUN);
   assign done     = (state == DONE);
   assign accept   = start && ready;
   assign last     = (cnt == CW'(N - 1));
   assign b_eff    = sub ? ~b_in : b_in;
   // New digit enters at the top; after N steps the LSB digit is at bit 0.
   assign s_ext    = WIDTH'(s) << (WIDTH - DIGIT);
   assign res_next = (res_sr >> DIGIT) | s_ext;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         res_sr  <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         sum_out <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            a_sr  <= a_in;
            b_sr  <= b_eff;
            carry <= cin ^ sub;
            a_msb <= a_in[WIDTH-1];
            b_msb <= b_eff[WIDTH-1];
            cnt   <= '0;
         end else if (state == RUN) begin
            a_sr   <= a_sr >> DIGIT;
            b_sr   <= b_sr >> DIGIT;
            res_sr <= res_next;
            carry  <= c;
            cnt    <= cnt + 1'b1;
            if (last) begin
               sum_out <= res_next;
               cout    <= c;
               ovf     <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder.
// Covers DIGIT=1 and DIGIT=4 instances sharing operand inputs.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start4;
   logic [7:0] a, b;
   logic       cin, sub;

   logic       ready8, done8, cout8, ovf8;
   logic [7:0] sum8;
   logic       ready4, done4, cout4, ovf4;
   logic [7:0] sum4;

   logic       sel;
   logic       ready_m, done_m, cout_m, ovf_m;
   logic [7:0] sum_m;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk(clk), .rst(rst), .start(start8),
      .a_in(a), .b_in(b), .cin(cin), .sub(sub),
      .ready(ready8), .done(done8), .sum_out(sum8),
      .cout(cout8), .ovf(ovf8)
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4),
      .a_in(a), .b_in(b), .cin(cin), .sub(sub),
      .ready(ready4), .done(done4), .sum_out(sum4),
      .cout(cout4), .ovf(ovf4)
   );

   assign ready_m = sel ? ready4 : ready8;
   assign done_m  = sel ? done4  : done8;
   assign sum_m   = sel ? sum4   : sum8;
   assign cout_m  = sel ? cout4  : cout8;
   assign ovf_m   = sel ? ovf4   : ovf8;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic set_start(input logic v);
      if (sel) start4 = v;
      else     start8 = v;
   endtask

   // Waits for done after an accept edge; returns cycles taken.
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!done_m && lat < 40);
      if (!done_m) chk("done_timeout", 0, 1);
   endtask

   task automatic run_op(input string tag, input logic d4,
                         input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic sb, input int n,
                         input logic [7:0] es, input logic ec,
                         input logic eo);
      int lat;
      sel = d4;
      @(negedge clk);
      a = av; b = bv; cin = ci; sub = sb;
      set_start(1'b1);
      @(posedge clk);
      #1;
      set_start(1'b0);
      a = 8'hxx; b = 8'hxx;
      chk({tag, "_busy"}, ready_m, 0);
      wait_done(lat);
      chk({tag, "_lat"}, lat, n);
      chk({tag, "_sum"}, sum_m, es);
      chk({tag, "_cout"}, cout_m, ec);
      chk({tag, "_ovf"}, ovf_m, eo);
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, done_m, 0);
      chk({tag, "_hold"}, sum_m, es);
   endtask

   initial begin
      int lat;
      int seen;
      sel = 0; rst = 1; start8 = 0; start4 = 0;
      a = 0; b = 0; cin = 0; sub = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready8", ready8, 1);
      chk("rst_done8", done8, 0);
      chk("rst_out8", {sum8, cout8, ovf8}, 0);
      chk("rst_ready4", ready4, 1);
      chk("rst_out4", {done4, sum4, cout4, ovf4}, 0);
      rst = 0;

      run_op("zero", 0, 8'h00, 8'h00, 0, 0, 8, 8'h00, 0, 0);
      run_op("ff_1", 0, 8'hFF, 8'h01, 0, 0, 8, 8'h00, 1, 0);
      run_op("7f_1", 0, 8'h7F, 8'h01, 0, 0, 8, 8'h80, 0, 1);
      run_op("sub5_7", 0, 8'h05, 8'h07, 0, 1, 8, 8'hFE, 0, 0);
      run_op("sub80_1", 0, 8'h80, 8'h01, 0, 1, 8, 8'h7F, 1, 1);

      // Reset during the 4th RUN cycle clears held results.
      sel = 0;
      @(negedge clk);
      a = 8'h11; b = 8'h22; cin = 0; sub = 0; start8 = 1;
      @(posedge clk);
      #1;
      start8 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      chk("mid_rst_ready", ready8, 1);
      chk("mid_rst_out", {done8, sum8, cout8, ovf8}, 0);
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (done8) seen++;
      end
      chk("mid_rst_nodone", seen, 0);

      // Reset and start together: start is dropped.
      @(negedge clk);
      rst = 1; start8 = 1;
      @(posedge clk);
      #1;
      rst = 0; start8 = 0;
      @(posedge clk);
      #1;
      chk("rst_start_idle", ready8, 1);

      run_op("fresh", 0, 8'h12, 8'h34, 0, 0, 8, 8'h46, 0, 0);

      // start held through RUN and DONE: back-to-back operation.
      sel = 0;
      @(negedge clk);
      a = 8'h01; b = 8'h02; cin = 0; sub = 0; start8 = 1;
      @(posedge clk);
      #1;
      a = 8'hAA; b = 8'h55;
      seen = 0;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
         if (ready8 && !done8) seen++;
      end while (!done8 && lat < 40);
      chk("b2b_ignore", seen, 0);
      chk("b2b_lat1", lat, 8);
      chk("b2b_sum1", sum8, 8'h03);
      a = 8'h10; b = 8'h20;
      wait_done(lat);
      start8 = 0;
      chk("b2b_lat2", lat, 9);
      chk("b2b_sum2", sum8, 8'h30);
      chk("b2b_cout2", {cout8, ovf8}, 0);

      run_op("d4", 1, 8'h3C, 8'h0A, 1, 0, 2, 8'h47, 0, 0);
      run_op("d4_sub", 1, 8'h80, 8'h01, 0, 1, 2, 8'h7F, 1, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
